selftrigger_arbiter: RTL and testbench

Collects self-trigger outputs from N_CH per-channel IIR/CFD trigger cores and queues one timestamped trigger request per event. Grants them round-robin to the single shared readout/frame-builder through a valid/ready handshake. After each granted trigger it applies a per-channel holdoff, and it counts triggers dropped while a channel is busy. Sits between the trigger cores and the readout.

---
 rtl/selftrigger_arbiter.sv | 173 +++++++++++++++++
 tb/tb_selftrigger_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/selftrigger_arbiter.sv
// selftrigger_arbiter
// Collects self-trigger edges from N_CH trigger cores, queues one timestamped
// request per channel, grants them round-robin to a single readout port via a
// valid/ready handshake, enforces a per-channel post-grant holdoff and keeps
// drop statistics for edges that arrive while a channel is busy.
module selftrigger_arbiter #(
   parameter int N_CH    = 8,
   parameter int HOLDOFF = 1024,
   parameter int TS_W    = 64,
   localparam int CH_W   = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [N_CH-1:0]   ch_mask,
   input  logic [N_CH-1:0]   trig_in,
   input  logic [TS_W-1:0]   ts_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH_W-1:0]   out_ch,
   output logic [TS_W-1:0]   out_ts,
   output logic [N_CH-1:0]   busy,
   output logic [N_CH-1:0]   drop_flags,
   output logic [15:0]       drop_count,
   input  logic              clear_stats
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_HOLDOFF = 2'd2
   } ch_state_t;

   // Counter load on grant; holdoff spans cnt = HOLDOFF-1 down to 0 inclusive.
   localparam logic [15:0] HOLD_LOAD = (HOLDOFF > 0) ? 16'(HOLDOFF - 1) : 16'd0;

   logic [N_CH-1:0]            trig_q;
   logic [N_CH-1:0]            armed_edge;
   logic [N_CH-1:0]            pending;
   logic [N_CH-1:0]            grant_vec;
   logic [N_CH-1:0]            drop_vec;
   logic [N_CH-1:0][TS_W-1:0]  ts_all;

   logic [CH_W-1:0]            rr_reg;
   logic [CH_W-1:0]            sel;
   logic                       any_pending;
   logic [4:0]                 drop_n;
   logic [16:0]                drop_sum;

   // Delay trigger levels by one cycle so a held level yields a single edge.
   always_ff @(posedge clk) begin
      if (reset) trig_q <= '0;
      else       trig_q <= trig_in;
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : ch_gen
         ch_state_t        state_reg;
         logic [15:0]      cnt_reg;
         logic [TS_W-1:0]  ts_reg;

         assign armed_edge[gi] = trig_in[gi] & ~trig_q[gi] & enable & ch_mask[gi];
         assign pending[gi]    = (state_reg == ST_PENDING);
         assign grant_vec[gi]  = out_valid & out_ready & (out_ch == CH_W'(gi));
         // The last holdoff cycle (cnt==0) may accept a fresh edge, so it is not a drop.
         assign drop_vec[gi]   = armed_edge[gi] &
                                 ((state_reg == ST_PENDING) |
                                  ((state_reg == ST_HOLDOFF) & (cnt_reg != 16'd0)));
         assign busy[gi]       = (state_reg != ST_IDLE);
         assign ts_all[gi]     = ts_reg;

         // Per-channel IDLE -> PENDING -> HOLDOFF lifecycle with timestamp capture.
         always_ff @(posedge clk) begin
            if (reset) begin
               state_reg <= ST_IDLE;
               cnt_reg   <= 16'd0;
               ts_reg    <= '0;
            end else begin
               case (state_reg)
                  ST_IDLE: begin
                     if (armed_edge[gi]) begin
                        state_reg <= ST_PENDING;
                        ts_reg    <= ts_in;
                     end
                  end
                  ST_PENDING: begin
                     if (grant_vec[gi]) begin
                        if (HOLDOFF == 0) begin
                           state_reg <= ST_IDLE;
                        end else begin
                           state_reg <= ST_HOLDOFF;
                           cnt_reg   <= HOLD_LOAD;
                        end
                     end
                  end
                  ST_HOLDOFF: begin
                     if (cnt_reg == 16'd0) begin
                        if (armed_edge[gi]) begin
                           state_reg <= ST_PENDING;
                           ts_reg    <= ts_in;
                        end else begin
                           state_reg <= ST_IDLE;
                        end
                     end else begin
                        cnt_reg <= cnt_reg - 16'd1;
                     end
                  end
                  default: state_reg <= ST_IDLE;
               endcase
            end
         end
      end
   endgenerate

   // Pick the first pending channel at or after the round-robin pointer.
   always_comb begin
      int idx;
      sel         = '0;
      any_pending = 1'b0;
      idx         = 0;
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(rr_reg) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!any_pending && pending[idx]) begin
            sel         = CH_W'(idx);
            any_pending = 1'b1;
         end
      end
   end

   // Registered grant: load a selection when empty, hold under backpressure.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_ts    <= '0;
         rr_reg    <= '0;
      end else if (out_valid) begin
         if (out_ready) begin
            out_valid <= 1'b0;
            rr_reg    <= (out_ch == CH_W'(N_CH - 1)) ? '0 : out_ch + 1'b1;
         end
      end else if (any_pending) begin
         out_valid <= 1'b1;
         out_ch    <= sel;
         out_ts    <= ts_all[sel];
      end
   end

   // Number of channels dropping an edge this cycle.
   always_comb begin
      drop_n = '0;
      for (int k = 0; k < N_CH; k++) begin
         drop_n = drop_n + {4'd0, drop_vec[k]};
      end
   end

   // A clear zeroes the old total first, so same-cycle drops still register.
   assign drop_sum = (clear_stats ? 17'd0 : {1'b0, drop_count}) + {12'd0, drop_n};

   // Sticky per-channel drop flags and saturating drop total.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_flags <= '0;
         drop_count <= 16'd0;
      end else begin
         drop_flags <= (clear_stats ? '0 : drop_flags) | drop_vec;
         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

endmodule

// File: tb/tb_selftrigger_arbiter.sv
// Directed testbench for selftrigger_arbiter (N_CH=8, HOLDOFF=4, TS_W=64).
// ts_in is the cycle number, so captured timestamps equal the detection cycle.
module tb_selftrigger_arbiter;

   localparam int N_CH = 8;
   localparam int HOLD = 4;
   localparam int TS_W = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic [N_CH-1:0]   ch_mask;
   logic [N_CH-1:0]   trig_in;
   logic [TS_W-1:0]   ts_in;
   logic              out_valid;
   logic              out_ready;
   logic [2:0]        out_ch;
   logic [TS_W-1:0]   out_ts;
   logic [N_CH-1:0]   busy;
   logic [N_CH-1:0]   drop_flags;
   logic [15:0]       drop_count;
   logic              clear_stats;

   logic [63:0]       cyc = 64'd0;
   int                n_cmp = 0;
   int                n_err = 0;
   logic [63:0]       c, b, h, g;

   selftrigger_arbiter #(.N_CH(N_CH), .HOLDOFF(HOLD), .TS_W(TS_W)) dut (
      .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
      .trig_in(trig_in), .ts_in(ts_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_ch(out_ch), .out_ts(out_ts), .busy(busy),
      .drop_flags(drop_flags), .drop_count(drop_count), .clear_stats(clear_stats)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 64'd1;
   assign ts_in = cyc;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_ch"},    64'(out_ch),    64'd0);
      chk({tag, "_ts"},    out_ts,         64'd0);
      chk({tag, "_busy"},  64'(busy),      64'd0);
      chk({tag, "_flags"}, 64'(drop_flags), 64'd0);
      chk({tag, "_count"}, 64'(drop_count), 64'd0);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; ch_mask = '0; trig_in = '0;
      out_ready = 1'b0; clear_stats = 1'b0;
      tick(); tick();
      chk_reset_outputs("reset");
      reset = 1'b0; enable = 1'b1; ch_mask = 8'hFF; out_ready = 1'b1;

      // Single trigger on ch3 at cycle 10, held high 50 cycles.
      for (int i = 0; i < 20 && cyc < 64'd10; i++) tick();
      chk("t1_start_cycle", cyc, 64'd10);
      trig_in[3] = 1'b1;
      tick();
      chk("t1_busy_pending", 64'(busy), 64'h08);
      chk("t1_valid_c11", 64'(out_valid), 64'd0);
      tick();
      chk("t1_valid_c12", 64'(out_valid), 64'd1);
      chk("t1_ch", 64'(out_ch), 64'd3);
      chk("t1_ts", out_ts, 64'd10);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("t1_busy_holdoff", 64'(busy), 64'h08);
         chk("t1_valid_holdoff", 64'(out_valid), 64'd0);
         tick();
      end
      chk("t1_busy_c17", 64'(busy), 64'd0);
      for (int i = 0; i < 60 && cyc < 64'd60; i++) begin
         chk("t1_no_regrant", 64'(out_valid), 64'd0);
         tick();
      end
      trig_in[3] = 1'b0;
      chk("t1_drop_count", 64'(drop_count), 64'd0);

      // Round-robin: ch0, ch2, ch5 together from a fresh pointer.
      reset = 1'b1; tick(); reset = 1'b0;
      c = cyc; trig_in = 8'h25;
      tick(); trig_in = '0;
      chk("rr_busy", 64'(busy), 64'h25);
      chk("rr_valid_c1", 64'(out_valid), 64'd0);
      tick();
      chk("rr_g1_valid", 64'(out_valid), 64'd1);
      chk("rr_g1_ch", 64'(out_ch), 64'd0);
      chk("rr_g1_ts", out_ts, c);
      tick();
      chk("rr_gap1", 64'(out_valid), 64'd0);
      tick();
      chk("rr_g2_valid", 64'(out_valid), 64'd1);
      chk("rr_g2_ch", 64'(out_ch), 64'd2);
      out_ready = 1'b0;
      tick(); chk("rr_stall_ch_a", 64'(out_ch), 64'd2);
      tick(); chk("rr_stall_ch_b", 64'(out_ch), 64'd2);
      tick();
      chk("rr_stall_ch_c", 64'(out_ch), 64'd2);
      chk("rr_ch0_idle", 64'(busy), 64'h24);
      trig_in = 8'h01;
      tick();
      chk("rr_ch0_rearmed", 64'(busy), 64'h25);
      chk("rr_stall_valid", 64'(out_valid), 64'd1);
      trig_in = '0; out_ready = 1'b1;
      tick();
      chk("rr_gap2", 64'(out_valid), 64'd0);
      tick();
      chk("rr_g3_valid", 64'(out_valid), 64'd1);
      chk("rr_g3_ch", 64'(out_ch), 64'd5);
      chk("rr_g3_ts", out_ts, c);
      tick();
      chk("rr_gap3", 64'(out_valid), 64'd0);
      tick();
      chk("rr_g4_valid", 64'(out_valid), 64'd1);
      chk("rr_g4_ch", 64'(out_ch), 64'd0);
      chk("rr_g4_ts", out_ts, c + 64'd7);
      repeat (7) tick();
      chk("rr_drained", 64'(busy), 64'd0);

      // Backpressure on ch1 with a dropped re-trigger while pending.
      out_ready = 1'b0;
      b = cyc; trig_in = 8'h02;
      tick(); trig_in = '0;
      tick();
      for (int k = 0; k < 20; k++) begin
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_ch", 64'(out_ch), 64'd1);
         chk("bp_ts", out_ts, b);
         if (k == 5) trig_in = 8'h02;
         if (k == 6) trig_in = '0;
         tick();
      end
      chk("bp_flags", 64'(drop_flags), 64'h02);
      chk("bp_count", 64'(drop_count), 64'd1);
      out_ready = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         chk("bp_single_grant", 64'(out_valid), 64'd0);
         tick();
      end
      chk("bp_drained", 64'(busy), 64'd0);

      // Holdoff boundary, run 1: edge with cnt==1 is dropped.
      h = cyc; trig_in = 8'h10;
      tick(); trig_in = '0;
      tick();
      chk("ho1_ch", 64'(out_ch), 64'd4);
      chk("ho1_ts", out_ts, h);
      tick(); tick(); tick();
      trig_in = 8'h10;
      tick(); trig_in = '0;
      chk("ho1_flags", 64'(drop_flags), 64'h12);
      chk("ho1_count", 64'(drop_count), 64'd2);
      tick();
      chk("ho1_idle", 64'(busy), 64'd0);
      for (int k = 0; k < 3; k++) begin
         chk("ho1_no_grant", 64'(out_valid), 64'd0);
         tick();
      end

      // Holdoff boundary, run 2: edge with cnt==0 is accepted.
      g = cyc; trig_in = 8'h10;
      tick(); trig_in = '0;
      tick();
      chk("ho2_ch", 64'(out_ch), 64'd4);
      tick(); tick(); tick(); tick();
      chk("ho2_in_holdoff", 64'(busy), 64'h10);
      trig_in = 8'h10;
      tick(); trig_in = '0;
      chk("ho2_pending", 64'(busy), 64'h10);
      chk("ho2_count_same", 64'(drop_count), 64'd2);
      tick();
      chk("ho2_valid", 64'(out_valid), 64'd1);
      chk("ho2_ch2", 64'(out_ch), 64'd4);
      chk("ho2_new_ts", out_ts, g + 64'd6);
      repeat (7) tick();
      chk("ho2_drained", 64'(busy), 64'd0);

      // Masked channel and disabled arm are ignored.
      ch_mask = 8'hBF; trig_in = 8'h40;
      tick(); trig_in = '0;
      for (int k = 0; k < 3; k++) begin
         chk("mask_busy", 64'(busy), 64'd0);
         chk("mask_valid", 64'(out_valid), 64'd0);
         tick();
      end
      chk("mask_count", 64'(drop_count), 64'd2);
      chk("mask_flags", 64'(drop_flags), 64'h12);
      ch_mask = 8'hFF; enable = 1'b0; trig_in = 8'h02;
      tick(); trig_in = '0;
      tick();
      chk("disable_busy", 64'(busy), 64'd0);
      chk("disable_count", 64'(drop_count), 64'd2);
      enable = 1'b1;

      // Saturation: all channels pending, 8 drops per toggle pair.
      out_ready = 1'b0; trig_in = 8'hFF;
      tick();
      chk("sat_all_pending", 64'(busy), 64'hFF);
      for (int i = 0; i < 8750; i++) begin
         trig_in = '0; tick();
         trig_in = 8'hFF; tick();
      end
      chk("sat_count", 64'(drop_count), 64'hFFFF);
      chk("sat_flags", 64'(drop_flags), 64'hFF);
      chk("sat_valid_held", 64'(out_valid), 64'd1);

      // clear_stats coincident with a single drop.
      trig_in = '0; tick();
      trig_in = 8'h01; clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      chk("clr_count", 64'(drop_count), 64'd1);
      chk("clr_flags", 64'(drop_flags), 64'h01);

      // Reset mid-handshake with every channel pending.
      chk("rst_pre_valid", 64'(out_valid), 64'd1);
      trig_in = '0; out_ready = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reset_outputs("rst_mid");
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rst_no_grant", 64'(out_valid), 64'd0);
         chk("rst_no_busy", 64'(busy), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
